// File: rtl/fifo_param.sv
// Parametrised single-clock FWFT FIFO with arbitrary depth, almost-full/almost-empty flags,
// synchronous flush and sticky overflow/underflow error flags.
module fifo_param #(
    parameter int unsigned BUSW  = 32,
    parameter int unsigned DEPTH = 32,
    localparam int unsigned PW   = $clog2(DEPTH),
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic [BUSW-1:0] datain,
    input  logic            pull,
    output logic [BUSW-1:0] dataout,
    output logic            full,
    output logic            empty,
    output logic [CW-1:0]   count,
    input  logic [CW-1:0]   afull_thresh,
    input  logic [CW-1:0]   aempty_thresh,
    output logic            almost_full,
    output logic            almost_empty,
    input  logic            flush,
    output logic            overflow,
    output logic            underflow,
    input  logic            err_clr
);

    localparam logic [PW-1:0] PtrLast = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CntFull = CW'(DEPTH);

    logic [BUSW-1:0] mem [DEPTH];

    logic [PW-1:0] h_q, h_d;
    logic [PW-1:0] t_q, t_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          wr_ok, rd_ok;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PtrLast) ? '0 : p + PW'(1);
    endfunction

    assign full         = (count_q == CntFull);
    assign empty        = (count_q == '0);
    assign count        = count_q;
    assign almost_full  = (count_q >= afull_thresh);
    assign almost_empty = (count_q <= aempty_thresh);
    assign overflow     = ovf_q;
    assign underflow    = unf_q;
    assign dataout      = empty ? '0 : mem[t_q];

    // A pull at full frees the slot the push needs in the same cycle.
    assign wr_ok = push && (!full || pull);
    assign rd_ok = pull && !empty;

    always_comb begin
        h_d     = h_q;
        t_d     = t_q;
        count_d = count_q;
        ovf_d   = ovf_q && !err_clr;
        unf_d   = unf_q && !err_clr;
        if (flush) begin
            h_d     = '0;
            t_d     = '0;
            count_d = '0;
        end else begin
            if (wr_ok) h_d = next_ptr(h_q);
            if (rd_ok) t_d = next_ptr(t_q);
            if (wr_ok && !rd_ok) begin
                count_d = count_q + CW'(1);
            end else if (rd_ok && !wr_ok) begin
                count_d = count_q - CW'(1);
            end
            if (push && full && !pull) ovf_d = 1'b1;
            if (pull && empty) unf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            h_q     <= '0;
            t_q     <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            h_q     <= h_d;
            t_q     <= t_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Storage is not reset; only written words are ever visible on dataout.
    always_ff @(posedge clk) begin
        if (rst && !flush && wr_ok) begin
            mem[h_q] <= datain;
        end
    end

endmodule

// File: tb/tb_fifo_param.sv
// Directed self-checking bench for fifo_param; three instances (DEPTH 4, 5, 8) share one
// stimulus stream and each test checks only the instance it targets.
module tb_fifo_param;

    localparam int unsigned BW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          push = 1'b0;
    logic          pull = 1'b0;
    logic          flush = 1'b0;
    logic          err_clr = 1'b0;
    logic [BW-1:0] datain = '0;
    logic [3:0]    af8 = 4'd6;
    logic [3:0]    ae8 = 4'd2;

    logic [BW-1:0] do4, do5, do8;
    logic          full4, full5, full8, empty4, empty5, empty8;
    logic [2:0]    cnt4, cnt5;
    logic [3:0]    cnt8;
    logic          af4, af5, afl8, ae4, ae5, ael8;
    logic          ovf4, ovf5, ovf8, unf4, unf5, unf8;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    fifo_param #(.BUSW(BW), .DEPTH(4)) u4 (
        .clk(clk), .rst(rst), .push(push), .datain(datain), .pull(pull), .dataout(do4),
        .full(full4), .empty(empty4), .count(cnt4), .afull_thresh(3'd3),
        .aempty_thresh(3'd1), .almost_full(af4), .almost_empty(ae4), .flush(flush),
        .overflow(ovf4), .underflow(unf4), .err_clr(err_clr)
    );

    fifo_param #(.BUSW(BW), .DEPTH(5)) u5 (
        .clk(clk), .rst(rst), .push(push), .datain(datain), .pull(pull), .dataout(do5),
        .full(full5), .empty(empty5), .count(cnt5), .afull_thresh(3'd4),
        .aempty_thresh(3'd1), .almost_full(af5), .almost_empty(ae5), .flush(flush),
        .overflow(ovf5), .underflow(unf5), .err_clr(err_clr)
    );

    fifo_param #(.BUSW(BW), .DEPTH(8)) u8 (
        .clk(clk), .rst(rst), .push(push), .datain(datain), .pull(pull), .dataout(do8),
        .full(full8), .empty(empty8), .count(cnt8), .afull_thresh(af8),
        .aempty_thresh(ae8), .almost_full(afl8), .almost_empty(ael8), .flush(flush),
        .overflow(ovf8), .underflow(unf8), .err_clr(err_clr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle with the given controls, then return everything to idle.
    task automatic step(input logic p, input logic [BW-1:0] d, input logic q);
        push   = p;
        datain = d;
        pull   = q;
        tick();
        push   = 1'b0;
        pull   = 1'b0;
        datain = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    logic [BW-1:0] exp_pop [8];

    initial begin
        // Reset / idle on DEPTH=4
        do_reset();
        check("rst_empty", 32'(empty4), 32'd1);
        check("rst_full", 32'(full4), 32'd0);
        check("rst_count", 32'(cnt4), 32'd0);
        check("rst_dataout", 32'(do4), 32'h0);
        check("rst_ovf", 32'(ovf4), 32'd0);
        check("rst_unf", 32'(unf4), 32'd0);
        check("rst_almost_full", 32'(af4), 32'd0);
        check("rst_almost_empty", 32'(ae4), 32'd1);

        // Fill/drain with wrap on DEPTH=5
        for (int i = 0; i < 5; i++) begin
            check("fill_not_full", 32'(full5), 32'd0);
            step(1'b1, BW'(8'hA1 + i), 1'b0);
        end
        check("fill_full", 32'(full5), 32'd1);
        check("fill_count5", 32'(cnt5), 32'd5);
        exp_pop = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hB1, 8'hB2, 8'hB3};
        for (int i = 0; i < 3; i++) begin
            check("pop_a", 32'(do5), 32'(exp_pop[i]));
            step(1'b0, '0, 1'b1);
        end
        check("drain_count2", 32'(cnt5), 32'd2);
        for (int i = 0; i < 3; i++) step(1'b1, BW'(8'hB1 + i), 1'b0);
        check("refill_count5", 32'(cnt5), 32'd5);
        check("refill_full", 32'(full5), 32'd1);
        for (int i = 3; i < 8; i++) begin
            check("pop_wrap", 32'(do5), 32'(exp_pop[i]));
            step(1'b0, '0, 1'b1);
        end
        check("drain_count0", 32'(cnt5), 32'd0);
        check("drain_empty", 32'(empty5), 32'd1);
        check("drain_dataout0", 32'(do5), 32'h0);

        // Full boundary on DEPTH=4
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, BW'(8'hC1 + i), 1'b0);
        check("full4_full", 32'(full4), 32'd1);
        check("full4_head", 32'(do4), 32'hC1);
        step(1'b1, 8'hD1, 1'b1);
        check("pp_full_count", 32'(cnt4), 32'd4);
        check("pp_full_head", 32'(do4), 32'hC2);
        check("pp_full_ovf", 32'(ovf4), 32'd0);
        step(1'b1, 8'hEE, 1'b0);
        check("ovf_set", 32'(ovf4), 32'd1);
        check("ovf_count", 32'(cnt4), 32'd4);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("ovf_clr", 32'(ovf4), 32'd0);
        exp_pop[0:3] = '{8'hC2, 8'hC3, 8'hC4, 8'hD1};
        for (int i = 0; i < 4; i++) begin
            check("pop_no_ee", 32'(do4), 32'(exp_pop[i]));
            step(1'b0, '0, 1'b1);
        end
        check("full4_drained", 32'(empty4), 32'd1);
        check("full4_no_unf", 32'(unf4), 32'd0);

        // Empty boundary: push+pull on empty
        check("pre_empty_dataout", 32'(do4), 32'h0);
        step(1'b1, 8'h55, 1'b1);
        check("eb_unf", 32'(unf4), 32'd1);
        check("eb_count", 32'(cnt4), 32'd1);
        check("eb_empty", 32'(empty4), 32'd0);
        check("eb_dataout", 32'(do4), 32'h55);
        // Set wins over err_clr in the same cycle.
        do_reset();
        err_clr = 1'b1;
        step(1'b0, '0, 1'b1);
        err_clr = 1'b0;
        check("set_beats_clr", 32'(unf4), 32'd1);

        // Thresholds on DEPTH=8 (afull 6, aempty 2)
        do_reset();
        check("thr_af_0", 32'(afl8), 32'd0);
        check("thr_ae_0", 32'(ael8), 32'd1);
        for (int k = 1; k <= 8; k++) begin
            step(1'b1, BW'(k), 1'b0);
            check("thr_af_up", 32'(afl8), 32'(k >= 6));
            check("thr_ae_up", 32'(ael8), 32'(k <= 2));
        end
        check("thr_full8", 32'(full8), 32'd1);
        for (int k = 7; k >= 0; k--) begin
            step(1'b0, '0, 1'b1);
            check("thr_af_dn", 32'(afl8), 32'(k >= 6));
            check("thr_ae_dn", 32'(ael8), 32'(k <= 2));
        end
        af8 = 4'd0;
        ae8 = 4'd8;
        #1;
        check("thr_af_zero", 32'(afl8), 32'd1);
        check("thr_ae_depth", 32'(ael8), 32'd1);

        // Flush then reset mid-operation on DEPTH=4
        do_reset();
        step(1'b0, '0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, BW'(8'h70 + i), 1'b0);
        check("fl_pre_count", 32'(cnt4), 32'd3);
        check("fl_pre_unf", 32'(unf4), 32'd1);
        flush = 1'b1;
        step(1'b1, 8'h99, 1'b0);
        flush = 1'b0;
        check("fl_count", 32'(cnt4), 32'd0);
        check("fl_empty", 32'(empty4), 32'd1);
        check("fl_unf_kept", 32'(unf4), 32'd1);
        check("fl_dataout", 32'(do4), 32'h0);
        flush = 1'b1;
        step(1'b0, '0, 1'b1);
        flush = 1'b0;
        check("fl_pull_no_err", 32'(cnt4), 32'd0);
        step(1'b1, 8'h81, 1'b0);
        step(1'b1, 8'h82, 1'b0);
        check("fl_refill_head", 32'(do4), 32'h81);
        check("fl_refill_count", 32'(cnt4), 32'd2);
        rst = 1'b0;
        step(1'b1, 8'h83, 1'b0);
        rst = 1'b1;
        check("mid_rst_count", 32'(cnt4), 32'd0);
        check("mid_rst_empty", 32'(empty4), 32'd1);
        check("mid_rst_unf", 32'(unf4), 32'd0);
        check("mid_rst_dataout", 32'(do4), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
